cpu_cu: RTL and testbench
=========================

Name: cpu_cu

Overview:
- Control unit (FSM) that drives the CPU execution unit's control inputs.
- Runs fetch/decode/execute over the 16-bit instruction register and branches on the ALU status flags C/N/Z.
- Issues the control word every cycle: register-file addresses and write enable, ALU op, S-mux select, PC load/increment, IR load, address select, memory write.
- Also provides a halted indication and a retired-instruction counter.

Parameters:
- PASS_R_OP, 4'h0, ALU_OP code that makes the ALU output equal the R operand; used for jumps and taken branches.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- IR  in  16  execution-unit IR output; fields: [15:12] alu_op, [11:9] class, [8:6] dest, [5:3] R, [2:0] S
- C, N, Z  in  1 each  ALU status flags from the execution unit
- W_En  out  1  memory write strobe
- pc_ld  out  1  load PC from ALU output
- pc_inc  out  1  increment PC
- adr_sel  out  1  0 = address is PC, 1 = address is register R
- S_Sel  out  1  1 = S operand comes from memory data (DS)
- reg_w_en  out  1  register-file write enable
- ir_ld  out  1  load IR from memory data
- W_Adr, R_Adr, S_Adr  out  3 each  register-file addresses
- ALU_OP  out  4  ALU operation
- halted  out  1  high while in HALT
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Outputs: Moore-decoded from the state register; IR field extraction is combinational. Every control not named for a state is 0.
- Reset: synchronous, active-high. Sampled reset moves the FSM to RST and clears flag registers fc/fn/fz and instr_cnt. All outputs are 0 in RST. RST -> FETCH unconditionally.
- Reset has priority in every state, including mid-instruction and HALT.
- FETCH: adr_sel=0, ir_ld=1, pc_inc=1. Next state: DECODE.
- DECODE: no strobes. Selects the next state from IR[11:9]:
  - 000 ALU -> EX_ALU
  - 001 LOAD -> LD_A
  - 010 STORE -> ST
  - 011 JMP -> JMP
  - 100 BRZ, 101 BRN, 110 BRC -> JMP if fz, fn or fc respectively is 1, else FETCH
  - 111 -> HALT
- EX_ALU: W_Adr=IR[8:6], R_Adr=IR[5:3], S_Adr=IR[2:0], ALU_OP=IR[15:12], reg_w_en=1. At this edge, latch C/N/Z into fc/fn/fz. Next: FETCH.
- LD_A: adr_sel=1, R_Adr=IR[5:3]. Next: LD_W.
- LD_W: adr_sel=1, R_Adr=IR[5:3], S_Sel=1, W_Adr=IR[8:6], reg_w_en=1. Next: FETCH.
- ST: adr_sel=1, R_Adr=IR[5:3], S_Adr=IR[2:0], W_En=1. Next: FETCH.
- JMP: R_Adr=IR[5:3], ALU_OP=PASS_R_OP, pc_ld=1. Next: FETCH.
- HALT: halted=1, all strobes 0. Stays in HALT until reset.
- Flags: updated only in EX_ALU; LOAD, STORE, jumps and branches leave them unchanged.
- Cycles per instruction, counted from FETCH:
  - ALU, STORE, JMP, taken branch: 3
  - LOAD: 4
  - Not-taken branch: 2
- instr_cnt: increments by 1 on the last cycle of each instruction (EX_ALU, LD_W, ST, JMP, not-taken-branch DECODE) and once on entry to HALT. Wraps modulo 2^CNT_W with no saturation.
- pc_ld and pc_inc are never both high.

Optional Feature:
- Macro: CPU_CU_STEP_EN (single-step debug).
- With the macro:
  - Added input port step (1 bit).
  - Every transition that would enter FETCH, except RST -> FETCH, enters STEP_WAIT instead.
  - STEP_WAIT: all outputs 0. Moves to FETCH on the first cycle step is sampled 1.
  - Reset exits STEP_WAIT.
- Without the macro: no step port, no STEP_WAIT state; timing exactly as above.

Decomposition:
- Package cpu_cu_pkg holds:
  - state encoding
  - class codes CLS_ALU..CLS_HALT
  - IR field bit positions
- One sub-module, cpu_cu_decode: combinational. IR -> class, dest/R/S/alu_op fields, and branch-taken given fc/fn/fz.
- The FSM, flag registers and counter stay in cpu_cu.

Test Plan:
- Reset, then release: cycle 1 in RST with all outputs 0; cycle 2 FETCH with ir_ld=1, pc_inc=1, adr_sel=0; instr_cnt=0.
- IR=16'hB051 (ALU op B, dest 1, R 2, S 1): EX_ALU drives W_Adr=1, R_Adr=2, S_Adr=1, ALU_OP=4'hB, reg_w_en=1. Driving Z=1 that cycle sets fz. instr_cnt=1 after 3 cycles.
- IR=16'h0288 (LOAD dest 2, R 1): LD_A adr_sel=1, R_Adr=1; LD_W adds S_Sel=1, reg_w_en=1, W_Adr=2. 4 cycles total; flags unchanged.
- With fz=1, IR=16'h0818 (BRZ, R 3): JMP cycle drives pc_ld=1, ALU_OP=PASS_R_OP, R_Adr=3. With fz=0: returns to FETCH after 2 cycles, no pc_ld, instr_cnt still increments.
- IR=16'h0E00 (HALT): halted=1 and strobes 0 for 20+ cycles, instr_cnt frozen. Asserting reset returns the FSM to RST, then FETCH.
- Reset asserted during LD_A: next cycle RST, reg_w_en never pulses. With CPU_CU_STEP_EN: after an ALU instruction the FSM waits in STEP_WAIT; a 1-cycle step pulse gives FETCH on the next cycle.

Source files
------------

// File: rtl/cpu_cu_pkg.sv
// Shared definitions for the cpu_cu control unit: FSM state encoding,
// instruction class codes and instruction-register field positions.
// Optional build macro: CPU_CU_STEP_EN adds the STEP_WAIT state.
package cpu_cu_pkg;

    // FSM state encoding
    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EX_ALU    = 4'd3,
        ST_LD_A      = 4'd4,
        ST_LD_W      = 4'd5,
        ST_STORE     = 4'd6,
        ST_JMP       = 4'd7,
`ifdef CPU_CU_STEP_EN
        ST_HALT      = 4'd8,
        ST_STEP_WAIT = 4'd9
`else
        ST_HALT      = 4'd8
`endif
    } state_t;

    // Instruction class codes, IR[11:9]
    localparam logic [2:0] CLS_ALU   = 3'b000;
    localparam logic [2:0] CLS_LOAD  = 3'b001;
    localparam logic [2:0] CLS_STORE = 3'b010;
    localparam logic [2:0] CLS_JMP   = 3'b011;
    localparam logic [2:0] CLS_BRZ   = 3'b100;
    localparam logic [2:0] CLS_BRN   = 3'b101;
    localparam logic [2:0] CLS_BRC   = 3'b110;
    localparam logic [2:0] CLS_HALT  = 3'b111;

    // Instruction register field bit positions
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int CLS_HI  = 11;
    localparam int CLS_LO  = 9;
    localparam int DEST_HI = 8;
    localparam int DEST_LO = 6;
    localparam int R_HI    = 5;
    localparam int R_LO    = 3;
    localparam int S_HI    = 2;
    localparam int S_LO    = 0;

endpackage

// File: rtl/cpu_cu_decode.sv
// Combinational instruction decoder: splits IR into its fields and
// resolves whether a conditional branch is taken from the saved flags.
module cpu_cu_decode
    import cpu_cu_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        fc,
    input  logic        fn,
    input  logic        fz,
    output logic [2:0]  cls,
    output logic [2:0]  dest,
    output logic [2:0]  r_fld,
    output logic [2:0]  s_fld,
    output logic [3:0]  alu_op,
    output logic        is_branch,
    output logic        br_taken
);

    assign cls    = ir[CLS_HI:CLS_LO];
    assign dest   = ir[DEST_HI:DEST_LO];
    assign r_fld  = ir[R_HI:R_LO];
    assign s_fld  = ir[S_HI:S_LO];
    assign alu_op = ir[OP_HI:OP_LO];

    // Each branch class tests exactly one saved flag; other classes never branch
    always_comb begin
        is_branch = 1'b0;
        br_taken  = 1'b0;
        case (cls)
            CLS_BRZ: begin is_branch = 1'b1; br_taken = fz; end
            CLS_BRN: begin is_branch = 1'b1; br_taken = fn; end
            CLS_BRC: begin is_branch = 1'b1; br_taken = fc; end
            default: begin is_branch = 1'b0; br_taken = 1'b0; end
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// cpu_cu: fetch/decode/execute control FSM for the CPU execution unit.
// Outputs are Moore-decoded from the state register, with IR fields
// routed combinationally. Holds the C/N/Z flag copies and a retired-
// instruction counter. Optional build macro: CPU_CU_STEP_EN adds a
// step input and a STEP_WAIT state in front of every non-reset FETCH.
module cpu_cu
    import cpu_cu_pkg::*;
#(
    parameter logic [3:0] PASS_R_OP = 4'h0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CPU_CU_STEP_EN
    input  logic             step,
`endif
    input  logic [15:0]      IR,
    input  logic             C,
    input  logic             N,
    input  logic             Z,
    output logic             W_En,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             adr_sel,
    output logic             S_Sel,
    output logic             reg_w_en,
    output logic             ir_ld,
    output logic [2:0]       W_Adr,
    output logic [2:0]       R_Adr,
    output logic [2:0]       S_Adr,
    output logic [3:0]       ALU_OP,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    // Where an instruction goes when it completes
`ifdef CPU_CU_STEP_EN
    localparam state_t NEXT_INSTR = ST_STEP_WAIT;
`else
    localparam state_t NEXT_INSTR = ST_FETCH;
`endif

    state_t           state_reg, state_next;
    logic             fc_reg, fn_reg, fz_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             retire;

    logic [2:0] cls, dest, r_fld, s_fld;
    logic [3:0] op_fld;
    logic       is_branch, br_taken;

    cpu_cu_decode u_decode (
        .ir        (IR),
        .fc        (fc_reg),
        .fn        (fn_reg),
        .fz        (fz_reg),
        .cls       (cls),
        .dest      (dest),
        .r_fld     (r_fld),
        .s_fld     (s_fld),
        .alu_op    (op_fld),
        .is_branch (is_branch),
        .br_taken  (br_taken)
    );

    // State register, flag copies and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RST;
            fc_reg    <= 1'b0;
            fn_reg    <= 1'b0;
            fz_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_EX_ALU) begin
                fc_reg <= C;
                fn_reg <= N;
                fz_reg <= Z;
            end
            if (retire) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Next-state selection and retire pulse on each instruction's last cycle
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            ST_RST:    state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_branch) begin
                    // A taken branch retires in JMP; a not-taken one here
                    if (br_taken) begin
                        state_next = ST_JMP;
                    end else begin
                        state_next = NEXT_INSTR;
                        retire     = 1'b1;
                    end
                end else begin
                    case (cls)
                        CLS_ALU:   state_next = ST_EX_ALU;
                        CLS_LOAD:  state_next = ST_LD_A;
                        CLS_STORE: state_next = ST_STORE;
                        CLS_JMP:   state_next = ST_JMP;
                        default: begin
                            // HALT counts once, on entry
                            state_next = ST_HALT;
                            retire     = 1'b1;
                        end
                    endcase
                end
            end
            ST_EX_ALU: begin state_next = NEXT_INSTR; retire = 1'b1; end
            ST_LD_A:   state_next = ST_LD_W;
            ST_LD_W:   begin state_next = NEXT_INSTR; retire = 1'b1; end
            ST_STORE:  begin state_next = NEXT_INSTR; retire = 1'b1; end
            ST_JMP:    begin state_next = NEXT_INSTR; retire = 1'b1; end
            ST_HALT:   state_next = ST_HALT;
`ifdef CPU_CU_STEP_EN
            ST_STEP_WAIT: begin
                if (step) begin
                    state_next = ST_FETCH;
                end
            end
`endif
            default:   state_next = ST_RST;
        endcase
    end

    // Moore control word; anything not named for a state stays 0
    always_comb begin
        W_En     = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        adr_sel  = 1'b0;
        S_Sel    = 1'b0;
        reg_w_en = 1'b0;
        ir_ld    = 1'b0;
        W_Adr    = 3'd0;
        R_Adr    = 3'd0;
        S_Adr    = 3'd0;
        ALU_OP   = 4'd0;
        halted   = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_EX_ALU: begin
                W_Adr    = dest;
                R_Adr    = r_fld;
                S_Adr    = s_fld;
                ALU_OP   = op_fld;
                reg_w_en = 1'b1;
            end
            ST_LD_A: begin
                adr_sel = 1'b1;
                R_Adr   = r_fld;
            end
            ST_LD_W: begin
                adr_sel  = 1'b1;
                R_Adr    = r_fld;
                S_Sel    = 1'b1;
                W_Adr    = dest;
                reg_w_en = 1'b1;
            end
            ST_STORE: begin
                adr_sel = 1'b1;
                R_Adr   = r_fld;
                S_Adr   = s_fld;
                W_En    = 1'b1;
            end
            ST_JMP: begin
                R_Adr  = r_fld;
                ALU_OP = PASS_R_OP;
                pc_ld  = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_cpu_cu.sv
// Scoreboard bench for cpu_cu: the stimulus process pushes the expected
// control word for each cycle; a monitor pops and compares on the falling
// edge. Directed instruction sequence with hand-computed values.
module tb_cpu_cu;

    typedef struct packed {
        logic        w_en;
        logic        pc_ld;
        logic        pc_inc;
        logic        adr_sel;
        logic        s_sel;
        logic        reg_w_en;
        logic        ir_ld;
        logic        halted;
        logic [2:0]  w_adr;
        logic [2:0]  r_adr;
        logic [2:0]  s_adr;
        logic [3:0]  alu_op;
        logic [15:0] cnt;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic        C = 1'b0, N = 1'b0, Z = 1'b0;
`ifdef CPU_CU_STEP_EN
    logic        step = 1'b0;
`endif
    logic        W_En, pc_ld, pc_inc, adr_sel, S_Sel, reg_w_en, ir_ld, halted;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  ALU_OP;
    logic [15:0] instr_cnt;

    ctl_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    cpu_cu #(.PASS_R_OP(4'h0), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CPU_CU_STEP_EN
        .step      (step),
`endif
        .IR        (IR),
        .C         (C),
        .N         (N),
        .Z         (Z),
        .W_En      (W_En),
        .pc_ld     (pc_ld),
        .pc_inc    (pc_inc),
        .adr_sel   (adr_sel),
        .S_Sel     (S_Sel),
        .reg_w_en  (reg_w_en),
        .ir_ld     (ir_ld),
        .W_Adr     (W_Adr),
        .R_Adr     (R_Adr),
        .S_Adr     (S_Adr),
        .ALU_OP    (ALU_OP),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expected control word per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e, g;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = '{W_En, pc_ld, pc_inc, adr_sel, S_Sel, reg_w_en, ir_ld, halted,
                   W_Adr, R_Adr, S_Adr, ALU_OP, instr_cnt};
            checks++;
            if (g === e) begin
                passed++;
            end else begin
                $display("FAIL %s: got %h required %h", nm, g, e);
            end
        end
    end

    // Push the expected word for the current cycle, then advance one cycle
    task automatic cyc(input ctl_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        $display("cycle %s IR=%h cnt_exp=%0d", nm, IR, e.cnt);
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t zero(input logic [15:0] cnt);
        ctl_t e;
        e     = '0;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic t_idle(input logic [15:0] cnt, input string nm);
        cyc(zero(cnt), nm);
    endtask

    task automatic t_fetch(input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        cyc(e, "fetch");
    endtask

    task automatic t_alu(input logic [2:0] w, input logic [2:0] r, input logic [2:0] s,
                         input logic [3:0] op, input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.w_adr = w; e.r_adr = r; e.s_adr = s; e.alu_op = op; e.reg_w_en = 1'b1;
        cyc(e, "ex_alu");
    endtask

    task automatic t_lda(input logic [2:0] r, input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.adr_sel = 1'b1; e.r_adr = r;
        cyc(e, "ld_a");
    endtask

    task automatic t_ldw(input logic [2:0] w, input logic [2:0] r, input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.adr_sel = 1'b1; e.r_adr = r; e.s_sel = 1'b1; e.w_adr = w; e.reg_w_en = 1'b1;
        cyc(e, "ld_w");
    endtask

    task automatic t_st(input logic [2:0] r, input logic [2:0] s, input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.adr_sel = 1'b1; e.r_adr = r; e.s_adr = s; e.w_en = 1'b1;
        cyc(e, "store");
    endtask

    task automatic t_jmp(input logic [2:0] r, input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.r_adr = r; e.alu_op = 4'h0; e.pc_ld = 1'b1;
        cyc(e, "jmp");
    endtask

    task automatic t_halt(input logic [15:0] cnt);
        ctl_t e;
        e = zero(cnt); e.halted = 1'b1;
        cyc(e, "halt");
    endtask

    initial begin
        // Cycle with reset sampled; state undefined before it, so not checked
        @(posedge clk);
        #1;
        reset = 1'b0;
        t_idle(0, "rst");

`ifdef CPU_CU_STEP_EN
        IR = 16'hB051;
        t_fetch(0);
        t_idle(0, "decode_alu");
        Z = 1'b0;
        t_alu(3'd1, 3'd2, 3'd1, 4'hB, 0);
        for (int i = 0; i < 3; i++) t_idle(1, "step_wait");
        step = 1'b1;
        t_idle(1, "step_wait_pulse");
        step = 1'b0;
        IR = 16'h0818;
        t_fetch(1);
        t_idle(1, "decode_brz_nt");
        t_idle(2, "step_wait2");
        step = 1'b1;
        t_idle(2, "step_wait2_pulse");
        step = 1'b0;
        t_fetch(2);
`else
        // ALU B051: dest 1, R 2, S 1, op B; Z=1 sets fz
        IR = 16'hB051;
        t_fetch(0);
        t_idle(0, "decode_alu");
        C = 1'b0; N = 1'b0; Z = 1'b1;
        t_alu(3'd1, 3'd2, 3'd1, 4'hB, 0);
        Z = 1'b0;
        // LOAD 0288: dest 2, R 1; flags must stay
        IR = 16'h0288;
        t_fetch(1);
        t_idle(1, "decode_ld");
        t_lda(3'd1, 1);
        t_ldw(3'd2, 3'd1, 1);
        // BRZ 0818 with fz=1: taken
        IR = 16'h0818;
        t_fetch(2);
        t_idle(2, "decode_brz_t");
        t_jmp(3'd3, 2);
        // ALU 3000 clears fz, sets fn
        IR = 16'h3000;
        t_fetch(3);
        t_idle(3, "decode_alu2");
        C = 1'b0; N = 1'b1; Z = 1'b0;
        t_alu(3'd0, 3'd0, 3'd0, 4'h3, 3);
        N = 1'b0;
        // BRZ with fz=0: not taken, 2 cycles
        IR = 16'h0818;
        t_fetch(4);
        t_idle(4, "decode_brz_nt");
        // BRN 0A18 with fn=1: taken
        IR = 16'h0A18;
        t_fetch(5);
        t_idle(5, "decode_brn_t");
        t_jmp(3'd3, 5);
        // BRC 0C18 with fc=0: not taken
        IR = 16'h0C18;
        t_fetch(6);
        t_idle(6, "decode_brc_nt");
        // STORE 042B: R 5, S 3; C=1 must not reach fc
        IR = 16'h042B;
        t_fetch(7);
        t_idle(7, "decode_st");
        C = 1'b1;
        t_st(3'd5, 3'd3, 7);
        C = 1'b0;
        // JMP 0610: R 2
        IR = 16'h0610;
        t_fetch(8);
        t_idle(8, "decode_jmp");
        t_jmp(3'd2, 8);
        // BRC still not taken
        IR = 16'h0C18;
        t_fetch(9);
        t_idle(9, "decode_brc_nt2");
        // Reset during LD_A: next cycle RST, no reg_w_en, count cleared
        IR = 16'h0288;
        t_fetch(10);
        t_idle(10, "decode_ld2");
        reset = 1'b1;
        t_lda(3'd1, 10);
        reset = 1'b0;
        t_idle(0, "rst_mid");
        // BRN after reset: fn cleared, not taken
        IR = 16'h0A18;
        t_fetch(0);
        t_idle(0, "decode_brn_nt");
        // HALT 0E00: counted once on entry, then frozen
        IR = 16'h0E00;
        t_fetch(1);
        t_idle(1, "decode_halt");
        for (int i = 0; i < 20; i++) t_halt(2);
        reset = 1'b1;
        t_halt(2);
        reset = 1'b0;
        t_idle(0, "rst_halt");
        t_fetch(0);
`endif
        // Let the monitor drain the last entry
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
